// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch sequencer and the decoder: opcodes,
// instruction field positions and the fetch state encoding.
package cpu_isa_pkg;

    localparam int INSTR_W     = 9;
    localparam int OPCODE_MSB  = 8;
    localparam int OPCODE_LSB  = 4;
    localparam int OPERAND_MSB = 3;
    localparam int OPERAND_LSB = 0;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_SETI = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [3:0] operand_of(input logic [INSTR_W-1:0] instr);
        return instr[OPERAND_MSB:OPERAND_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives pc to an external ROM and registers the
// fetched instruction. Define FETCH_COUNT_EN to add the fetch_count output.
module fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd1,
    parameter logic [4:0]  HALT_OP  = OP_HALT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [15:0]         redirect_pc,
    input  logic [INSTR_W-1:0]  rom_instr,
    output logic [15:0]         pc,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [15:0]         if_pc,
    output logic                halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]         fetch_count
`endif
);

    fetch_state_t       state_reg, state_next;
    logic [15:0]        pc_reg, pc_next;
    logic               valid_reg, valid_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [15:0]        if_pc_reg, if_pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            if_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            if_pc_reg <= if_pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        if_pc_next = if_pc_reg;
        case (state_reg)
            ST_IDLE: begin
                pc_next    = RESET_PC;
                valid_next = 1'b0;
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Redirect outranks both stall and halt detection.
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    instr_next = rom_instr;
                    if_pc_next = pc_reg;
                    valid_next = 1'b1;
                    if (opcode_of(rom_instr) == HALT_OP) state_next = ST_HALTED;
                    else                                 pc_next    = pc_reg + 16'd1;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end else if (!stall) begin
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = RESET_PC;
                valid_next = 1'b0;
            end
        endcase
    end

    assign pc       = pc_reg;
    assign if_valid = valid_reg;
    assign if_instr = instr_reg;
    assign if_pc    = if_pc_reg;
    assign halted   = (state_reg == ST_HALTED);

`ifdef FETCH_COUNT_EN
    logic [15:0] count_reg, count_next;

    // Start only clears the count when it is actually accepted (not in FETCH).
    always_comb begin
        count_next = count_reg;
        if (start && (state_reg != ST_FETCH))
            count_next = '0;
        else if (valid_reg && !stall && (count_reg != 16'hFFFF))
            count_next = count_reg + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_reg <= '0;
        else        count_reg <= count_next;
    end

    assign fetch_count = count_reg;
`endif

endmodule
